// File: rtl/config_chain_loader_pkg.sv
// -----------------------------------------------------------------------------
// config_chain_loader_pkg
// Shared definitions for the configuration chain loader: FSM state encodings,
// default word width / chain length, and a small state-classification helper.
// These constants are also the ones the host-side bus bridge relies on.
// -----------------------------------------------------------------------------
package config_chain_loader_pkg;

   // Loader FSM states. DONE behaves like IDLE but keeps the done flag high.
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_WORD = 3'd1,
      ST_SHIFT     = 3'd2,
      ST_SET       = 3'd3,
      ST_DONE      = 3'd4
   } cfg_state_e;

   // Default host word width and chain length.
   localparam int CFG_WORD_W    = 32;
   localparam int CFG_CHAIN_LEN = 1024;

   // A load is in progress (busy) in WAIT_WORD, SHIFT and SET.
   function automatic logic state_is_busy(input cfg_state_e s);
      logic r;
      case (s)
         ST_WAIT_WORD: r = 1'b1;
         ST_SHIFT:     r = 1'b1;
         ST_SET:       r = 1'b1;
         default:      r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/config_chain_loader_word_serializer.sv
// -----------------------------------------------------------------------------
// config_chain_loader_word_serializer
// Holds one host config word and shifts it out LSB-first, counting the bits of
// the current word so the loader knows when the word is exhausted.
//
// Ports
//   clk        in   fabric clock
//   rst        in   asynchronous active-low reset
//   i_clear    in   drop the held word and bit count (load cancelled)
//   i_load     in   capture i_data, restart the bit count
//   i_shift    in   advance one bit (word >> 1, bit count + 1)
//   i_data     in   WORD_W-bit config word
//   o_bit0_nxt out  value bit 0 of the word register will hold after this
//                   clock edge; lets the top register shift_out directly
//   o_last     out  the bit currently at position 0 is the word's last bit
// -----------------------------------------------------------------------------
module config_chain_loader_word_serializer #(
   parameter int WORD_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_clear,
   input  logic              i_load,
   input  logic              i_shift,
   input  logic [WORD_W-1:0] i_data,
   output logic              o_bit0_nxt,
   output logic              o_last
);

   localparam int WB_W = $clog2(WORD_W);
   localparam logic [WB_W-1:0] WB_LAST = WB_W'(WORD_W - 1);

   logic [WORD_W-1:0] r_sreg;
   logic [WB_W-1:0]   r_word_bit;
   logic              w_bit0_nxt;

   // Word shift register and per-word bit counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sreg     <= '0;
         r_word_bit <= '0;
      end else if (i_clear) begin
         r_sreg     <= '0;
         r_word_bit <= '0;
      end else if (i_load) begin
         r_sreg     <= i_data;
         r_word_bit <= '0;
      end else if (i_shift) begin
         r_sreg <= r_sreg >> 1;
         // Hold at the last index: the word is either reloaded or the load ends.
         if (r_word_bit != WB_LAST) begin
            r_word_bit <= r_word_bit + WB_W'(1);
         end else begin
            r_word_bit <= r_word_bit;
         end
      end else begin
         r_sreg     <= r_sreg;
         r_word_bit <= r_word_bit;
      end
   end

   // Look-ahead of bit 0, mirroring the register update priority above.
   always_comb begin
      w_bit0_nxt = r_sreg[0];
      if (i_clear) begin
         w_bit0_nxt = 1'b0;
      end else if (i_load) begin
         w_bit0_nxt = i_data[0];
      end else if (i_shift) begin
         w_bit0_nxt = r_sreg[1];
      end else begin
         w_bit0_nxt = r_sreg[0];
      end
   end

   assign o_bit0_nxt = w_bit0_nxt;
   assign o_last     = (r_word_bit == WB_LAST);

endmodule

// File: rtl/config_chain_loader.sv
// -----------------------------------------------------------------------------
// config_chain_loader
// Master end of the fabric configuration shift chain. Takes config words from
// the host over a valid/ready stream, serializes them LSB-first onto the chain
// head, drives cen for exactly CHAIN_LEN cycles and then pulses set_out once so
// every tile latches its bits. cen and set_out are never high together.
//
// Ports
//   clk        in   fabric clock
//   rst        in   asynchronous active-low reset
//   start      in   begin a load (honoured only in IDLE/DONE)
//   abort      in   cancel the load, back to IDLE, no set pulse
//   cfg_data   in   WORD_W-bit config word, bit 0 shifted first
//   cfg_valid  in   cfg_data valid
//   cfg_ready  out  word accepted this cycle when cfg_valid is also high
//   shift_out  out  serial data to the chain head (0 while cen is low)
//   cen        out  chain shift enable
//   set_out    out  one-cycle config latch pulse
//   busy       out  load in progress
//   done       out  sticky completion flag
// All outputs are flops loaded from the next-state decode, so no input has a
// combinational path to an output.
// -----------------------------------------------------------------------------
module config_chain_loader
   import config_chain_loader_pkg::*;
#(
   parameter int CHAIN_LEN = CFG_CHAIN_LEN,
   parameter int WORD_W    = CFG_WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] cfg_data,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   output logic              shift_out,
   output logic              cen,
   output logic              set_out,
   output logic              busy,
   output logic              done
);

   localparam int BC_W = $clog2(CHAIN_LEN + 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(CHAIN_LEN - 1);

   cfg_state_e      r_state;
   cfg_state_e      w_state_nxt;
   logic [BC_W-1:0] r_bit_cnt;

   logic w_start_acc;
   logic w_load;
   logic w_shift;
   logic w_bit0_nxt;
   logic w_word_last;

   logic r_cfg_ready;
   logic r_shift_out;
   logic r_cen;
   logic r_set;
   logic r_busy;
   logic r_done;

   // abort outranks everything, including start and a word offered that cycle.
   assign w_start_acc = start & ~abort & ((r_state == ST_IDLE) | (r_state == ST_DONE));
   assign w_load      = cfg_valid & ~abort & (r_state == ST_WAIT_WORD);
   assign w_shift     = ~abort & (r_state == ST_SHIFT);

   config_chain_loader_word_serializer #(
      .WORD_W (WORD_W)
   ) u_serializer (
      .clk        (clk),
      .rst        (rst),
      .i_clear    (abort),
      .i_load     (w_load),
      .i_shift    (w_shift),
      .i_data     (cfg_data),
      .o_bit0_nxt (w_bit0_nxt),
      .o_last     (w_word_last)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      if (abort) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  w_state_nxt = ST_WAIT_WORD;
               end else begin
                  w_state_nxt = r_state;
               end
            end
            ST_WAIT_WORD: begin
               if (cfg_valid) begin
                  w_state_nxt = ST_SHIFT;
               end else begin
                  w_state_nxt = ST_WAIT_WORD;
               end
            end
            ST_SHIFT: begin
               // End of chain beats end of word: leftover word bits are dropped
               // and no further word is requested.
               if (r_bit_cnt == BC_LAST) begin
                  w_state_nxt = ST_SET;
               end else if (w_word_last) begin
                  w_state_nxt = ST_WAIT_WORD;
               end else begin
                  w_state_nxt = ST_SHIFT;
               end
            end
            ST_SET: begin
               w_state_nxt = ST_DONE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Chain bit counter: cleared at start/abort, counts every shifted bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bit_cnt <= '0;
      end else if (abort || w_start_acc) begin
         r_bit_cnt <= '0;
      end else if (w_shift) begin
         r_bit_cnt <= r_bit_cnt + BC_W'(1);
      end else begin
         r_bit_cnt <= r_bit_cnt;
      end
   end

   // Output flops, loaded from the state being entered so they align with it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cfg_ready <= 1'b0;
         r_shift_out <= 1'b0;
         r_cen       <= 1'b0;
         r_set       <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_cfg_ready <= (w_state_nxt == ST_WAIT_WORD);
         r_shift_out <= (w_state_nxt == ST_SHIFT) & w_bit0_nxt;
         r_cen       <= (w_state_nxt == ST_SHIFT);
         r_set       <= (w_state_nxt == ST_SET);
         r_busy      <= state_is_busy(w_state_nxt);
         r_done      <= (w_state_nxt == ST_DONE);
      end
   end

   assign cfg_ready = r_cfg_ready;
   assign shift_out = r_shift_out;
   assign cen       = r_cen;
   assign set_out   = r_set;
   assign busy      = r_busy;
   assign done      = r_done;

endmodule

// File: tb/tb_config_chain_loader.sv
// -----------------------------------------------------------------------------
// tb_config_chain_loader
// Two loaders: index 0 with CHAIN_LEN=10, index 1 with CHAIN_LEN=8 (exact
// multiple of WORD_W=4). A negedge monitor models each chain as a shift
// register plus set latch; expected chain images are built directly from the
// host words (image bit b = bit b%4 of word b/4).
// -----------------------------------------------------------------------------
module tb_config_chain_loader;

   logic clk = 1'b0;
   logic rst;

   logic       start_s     [2];
   logic       abort_s     [2];
   logic       cfg_valid_s [2];
   logic [3:0] cfg_data_s  [2];
   logic       cfg_ready_w [2];
   logic       shift_out_w [2];
   logic       cen_w       [2];
   logic       set_out_w   [2];
   logic       busy_w      [2];
   logic       done_w      [2];

   int n_vec = 0;
   int n_err = 0;

   // Monitor state per DUT.
   int          cen_cnt  [2] = '{0, 0};
   int          set_cnt  [2] = '{0, 0};
   int          xfer_cnt [2] = '{0, 0};
   int          busy_cnt [2] = '{0, 0};
   int          viol_cnt [2] = '{0, 0};
   logic [15:0] chain    [2] = '{16'h0, 16'h0};
   logic [15:0] latched  [2] = '{16'h0, 16'h0};
   logic        prev_cen [2] = '{1'b0, 1'b0};

   always #5 clk = ~clk;

   config_chain_loader #(.CHAIN_LEN(10), .WORD_W(4)) u_dut10 (
      .clk(clk), .rst(rst), .start(start_s[0]), .abort(abort_s[0]),
      .cfg_data(cfg_data_s[0]), .cfg_valid(cfg_valid_s[0]), .cfg_ready(cfg_ready_w[0]),
      .shift_out(shift_out_w[0]), .cen(cen_w[0]), .set_out(set_out_w[0]),
      .busy(busy_w[0]), .done(done_w[0])
   );

   config_chain_loader #(.CHAIN_LEN(8), .WORD_W(4)) u_dut8 (
      .clk(clk), .rst(rst), .start(start_s[1]), .abort(abort_s[1]),
      .cfg_data(cfg_data_s[1]), .cfg_valid(cfg_valid_s[1]), .cfg_ready(cfg_ready_w[1]),
      .shift_out(shift_out_w[1]), .cen(cen_w[1]), .set_out(set_out_w[1]),
      .busy(busy_w[1]), .done(done_w[1])
   );

   function automatic int clen(input int k);
      return (k == 0) ? 10 : 8;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Chain model and protocol bookkeeping, sampled mid-cycle.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            if (cen_w[k]) begin
               cen_cnt[k] <= cen_cnt[k] + 1;
               chain[k]   <= (chain[k] >> 1) | (16'(shift_out_w[k]) << (clen(k) - 1));
            end else if (shift_out_w[k]) begin
               viol_cnt[k] <= viol_cnt[k] + 1;
            end
            if (set_out_w[k]) begin
               set_cnt[k] <= set_cnt[k] + 1;
               latched[k] <= chain[k];
               if (cen_w[k] || !prev_cen[k]) viol_cnt[k] <= viol_cnt[k] + 1;
            end
            if (busy_w[k]) busy_cnt[k] <= busy_cnt[k] + 1;
            if (cfg_valid_s[k] && cfg_ready_w[k] && !abort_s[k]) xfer_cnt[k] <= xfer_cnt[k] + 1;
            prev_cen[k] <= cen_w[k];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One full load of pattern nibbles into DUT k.
   // stall_mode: 0 back-to-back, 1 long gap before word 1, 2 random gaps.
   task automatic run_load(input int k, input int stall_mode, input logic [15:0] pat, input bit start_mid);
      int len, nw, c0, s0, x0, b0, t, st;
      logic [15:0] exp;
      logic [3:0]  wd;
      len = clen(k);
      nw  = (len + 3) / 4;
      exp = '0;
      for (int b = 0; b < len; b++) begin
         wd     = pat[4*(b/4) +: 4];
         exp[b] = wd[b%4];
      end
      c0 = cen_cnt[k]; s0 = set_cnt[k]; x0 = xfer_cnt[k]; b0 = busy_cnt[k];
      start_s[k] = 1'b1;
      step();
      start_s[k] = 1'b0;
      check_eq("start_busy", 32'(busy_w[k]), 32'd1);
      check_eq("start_done_clr", 32'(done_w[k]), 32'd0);
      for (int i = 0; i < nw; i++) begin
         st = (stall_mode == 2) ? int'($urandom_range(0, 3)) : ((stall_mode == 1 && i == 1) ? 8 : 0);
         cfg_valid_s[k] = 1'b0;
         repeat (st) step();
         cfg_valid_s[k] = 1'b1;
         cfg_data_s[k]  = pat[4*i +: 4];
         t = 0;
         while (!cfg_ready_w[k] && t < 100) begin
            step();
            t++;
         end
         check_eq("word_ready_timeout", 32'(t < 100), 32'd1);
         step();
         cfg_valid_s[k] = 1'b0;
         if (start_mid && i == 0) begin
            start_s[k] = 1'b1;
            step();
            start_s[k] = 1'b0;
         end
      end
      // Keep offering an excess word: it must never be consumed.
      cfg_valid_s[k] = 1'b1;
      cfg_data_s[k]  = 4'($urandom);
      t = 0;
      while (!done_w[k] && t < 100) begin
         step();
         t++;
      end
      check_eq("done_timeout", 32'(t < 100), 32'd1);
      check_eq("cen_cycles", cen_cnt[k] - c0, len);
      check_eq("set_pulses", set_cnt[k] - s0, 32'd1);
      check_eq("chain_image", 32'(latched[k]), 32'(exp));
      check_eq("words_taken", xfer_cnt[k] - x0, nw);
      check_eq("done_high", 32'(done_w[k]), 32'd1);
      check_eq("busy_low", 32'(busy_w[k]), 32'd0);
      check_eq("protocol_viol", viol_cnt[k], 32'd0);
      if (stall_mode == 0) check_eq("busy_cycles", busy_cnt[k] - b0, nw + len + 1);
      repeat (2) step();
      check_eq("excess_not_taken", xfer_cnt[k] - x0, nw);
      check_eq("ready_low_after", 32'(cfg_ready_w[k]), 32'd0);
      cfg_valid_s[k] = 1'b0;
   endtask

   initial begin
      int c0, s0, x0, t;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         start_s[k] = 1'b0; abort_s[k] = 1'b0; cfg_valid_s[k] = 1'b0; cfg_data_s[k] = 4'h0;
      end
      repeat (3) step();
      for (int k = 0; k < 2; k++) begin
         check_eq("rst_cen", 32'(cen_w[k]), 32'd0);
         check_eq("rst_set", 32'(set_out_w[k]), 32'd0);
         check_eq("rst_busy", 32'(busy_w[k]), 32'd0);
         check_eq("rst_done", 32'(done_w[k]), 32'd0);
         check_eq("rst_ready", 32'(cfg_ready_w[k]), 32'd0);
         check_eq("rst_sout", 32'(shift_out_w[k]), 32'd0);
      end
      rst = 1'b1;
      step();

      // Directed loads: back-to-back, long gap, start mid-shift, exact multiple.
      run_load(0, 0, 16'h03A5, 1'b0);
      check_eq("img_3A5", 32'(latched[0]), 32'h3A5);
      run_load(0, 1, 16'h03A5, 1'b0);
      run_load(0, 0, 16'h0C3B, 1'b1);
      run_load(1, 0, 16'h00C6, 1'b0);
      run_load(1, 1, 16'h005A, 1'b1);

      // Abort after 6 shifted bits.
      c0 = cen_cnt[0]; s0 = set_cnt[0];
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      cfg_valid_s[0] = 1'b1;
      t = 0;
      while ((cen_cnt[0] - c0) < 6 && t < 100) begin
         cfg_data_s[0] = 4'($urandom);
         step();
         t++;
      end
      check_eq("abort_wait_timeout", 32'(t < 100), 32'd1);
      abort_s[0] = 1'b1;
      step();
      abort_s[0] = 1'b0;
      cfg_valid_s[0] = 1'b0;
      check_eq("abort_cen", 32'(cen_w[0]), 32'd0);
      check_eq("abort_busy", 32'(busy_w[0]), 32'd0);
      check_eq("abort_done", 32'(done_w[0]), 32'd0);
      check_eq("abort_ready", 32'(cfg_ready_w[0]), 32'd0);
      repeat (4) step();
      check_eq("abort_no_set", set_cnt[0] - s0, 32'd0);
      check_eq("abort_cen_cycles", cen_cnt[0] - c0, 32'd7);

      // Abort in WAIT_WORD with a word on offer: word must not be taken.
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      x0 = xfer_cnt[0];
      cfg_valid_s[0] = 1'b1;
      abort_s[0] = 1'b1;
      step();
      abort_s[0] = 1'b0;
      check_eq("abort_wait_busy", 32'(busy_w[0]), 32'd0);
      repeat (3) step();
      check_eq("abort_wait_xfer", xfer_cnt[0] - x0, 32'd0);
      check_eq("abort_wait_cen", 32'(cen_w[0]), 32'd0);
      cfg_valid_s[0] = 1'b0;

      // abort and start together: abort wins.
      start_s[0] = 1'b1;
      abort_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      abort_s[0] = 1'b0;
      check_eq("abort_start_busy", 32'(busy_w[0]), 32'd0);
      run_load(0, 0, 16'h0FFF, 1'b0);
      check_eq("img_3FF", 32'(latched[0]), 32'h3FF);

      // Asynchronous reset in the middle of SHIFT.
      c0 = cen_cnt[0]; s0 = set_cnt[0];
      start_s[0] = 1'b1;
      step();
      start_s[0] = 1'b0;
      cfg_valid_s[0] = 1'b1;
      t = 0;
      while ((cen_cnt[0] - c0) < 3 && t < 100) begin
         step();
         t++;
      end
      check_eq("rst_wait_timeout", 32'(t < 100), 32'd1);
      rst = 1'b0;
      #2;
      check_eq("arst_cen", 32'(cen_w[0]), 32'd0);
      check_eq("arst_sout", 32'(shift_out_w[0]), 32'd0);
      check_eq("arst_busy", 32'(busy_w[0]), 32'd0);
      check_eq("arst_ready", 32'(cfg_ready_w[0]), 32'd0);
      repeat (2) step();
      rst = 1'b1;
      repeat (5) step();
      check_eq("post_rst_idle", 32'(busy_w[0]), 32'd0);
      check_eq("post_rst_ready", 32'(cfg_ready_w[0]), 32'd0);
      check_eq("post_rst_no_set", set_cnt[0] - s0, 32'd0);
      cfg_valid_s[0] = 1'b0;
      step();

      // Randomized loads on both chains.
      for (int n = 0; n < 24; n++) begin
         run_load(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 16'($urandom),
                  1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
